// File: rtl/mips_pkg.sv
// Shared constants for the MIPS single-cycle datapath.
// These cover register widths, the register count and the $zero index.
package mips_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/register_file.sv
// 32 x 32 MIPS general-purpose register file.
// It has two combinational read ports and one synchronous write port, with r0 hardwired to zero.
module register_file
  import mips_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] rs1_reg,
  input  logic [AW-1:0] rs2_reg,
  input  logic [AW-1:0] rw_reg,
  input  logic          reg_write,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rs1_read,
  output logic [DW-1:0] rs2_read
);

  localparam int NR = 2 ** AW;
  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [DW-1:0] regs [0:NR-1];
  logic          wr_en;

  // A write to r0 is dropped here, so the r0 storage is never loaded.
  assign wr_en = reg_write && (rw_reg != ZERO_IDX);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NR; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[rw_reg] <= wr_data;
    end
  end

  // The read muxes force r0 to zero, even before the first reset edge.
  assign rs1_read = (rs1_reg == ZERO_IDX) ? '0 : regs[rs1_reg];
  assign rs2_read = (rs2_reg == ZERO_IDX) ? '0 : regs[rs2_reg];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file.
// Each table vector is applied for one clock, and the expected reads go to a scoreboard queue.
module tb_register_file;
  import mips_pkg::*;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic [ADDR_WIDTH-1:0] rs1_reg, rs2_reg, rw_reg;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rs1_read, rs2_read;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic                  rst_n;
    logic                  we;
    logic [ADDR_WIDTH-1:0] rw;
    logic [DATA_WIDTH-1:0] wd;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0] e1;
    logic [DATA_WIDTH-1:0] e2;
  } vec_t;

  typedef struct {
    string                 name;
    logic [DATA_WIDTH-1:0] e1;
    logic [DATA_WIDTH-1:0] e2;
  } exp_t;

  exp_t sb[$];

  register_file dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .rs1_reg  (rs1_reg),
    .rs2_reg  (rs2_reg),
    .rw_reg   (rw_reg),
    .reg_write(reg_write),
    .wr_data  (wr_data),
    .rs1_read (rs1_read),
    .rs2_read (rs2_read)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d checks, required completion", checks);
    $fatal(1, "watchdog");
  end

  task automatic drive(input vec_t v);
    i_rst_n   = v.rst_n;
    reg_write = v.we;
    rw_reg    = v.rw;
    wr_data   = v.wd;
    rs1_reg   = v.rs1;
    rs2_reg   = v.rs2;
  endtask

  task automatic push(input string name, input logic [DATA_WIDTH-1:0] e1,
                      input logic [DATA_WIDTH-1:0] e2);
    exp_t x;
    x.name = name;
    x.e1   = e1;
    x.e2   = e2;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got no entry, required one");
      return;
    end
    x = sb.pop_front();
    checks++;
    if (rs1_read !== x.e1) begin
      errors++;
      $display("FAIL %s rs1_read: got %h required %h", x.name, rs1_read, x.e1);
    end
    checks++;
    if (rs2_read !== x.e2) begin
      errors++;
      $display("FAIL %s rs2_read: got %h required %h", x.name, rs2_read, x.e2);
    end
    $display("txn %-10s rs1=%0d rs2=%0d -> %h %h (exp %h %h)",
             x.name, rs1_reg, rs2_reg, rs1_read, rs2_read, x.e1, x.e2);
  endtask

  // Apply the vector on the falling edge, then compare just after the next rising edge.
  task automatic apply(input string name, input vec_t v);
    @(negedge i_clk);
    drive(v);
    push(name, v.e1, v.e2);
    @(posedge i_clk);
    #1;
    pop_check();
  endtask

  vec_t vecs[13];
  vec_t v;

  initial begin
    //           rst  we  rw     wd             rs1    rs2    e1             e2
    vecs[0]  = '{1'b0, 1'b0, 5'd0,  32'd0,         5'd5,  5'd31, 32'd0,         32'd0};
    vecs[1]  = '{1'b0, 1'b0, 5'd0,  32'd0,         5'd5,  5'd31, 32'd0,         32'd0};
    vecs[2]  = '{1'b1, 1'b1, 5'd1,  32'd68,        5'd1,  5'd2,  32'd68,        32'd0};
    vecs[3]  = '{1'b1, 1'b1, 5'd2,  32'd48,        5'd1,  5'd2,  32'd68,        32'd48};
    vecs[4]  = '{1'b1, 1'b0, 5'd0,  32'd0,         5'd2,  5'd1,  32'd48,        32'd68};
    vecs[5]  = '{1'b1, 1'b1, 5'd0,  32'd43,        5'd0,  5'd1,  32'd0,         32'd68};
    vecs[6]  = '{1'b1, 1'b1, 5'd3,  32'd73,        5'd3,  5'd0,  32'd73,        32'd0};
    vecs[7]  = '{1'b1, 1'b0, 5'd3,  32'd88,        5'd3,  5'd3,  32'd73,        32'd73};
    vecs[8]  = '{1'b1, 1'b0, 5'd3,  32'd88,        5'd3,  5'd3,  32'd73,        32'd73};
    vecs[9]  = '{1'b1, 1'b0, 5'd3,  32'd88,        5'd3,  5'd3,  32'd73,        32'd73};
    vecs[10] = '{1'b1, 1'b1, 5'd4,  32'd86,        5'd4,  5'd4,  32'd86,        32'd86};
    vecs[11] = '{1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd30, 32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{1'b1, 1'b1, 5'd30, 32'hA5A5_5A5A, 5'd30, 5'd31, 32'hA5A5_5A5A, 32'hFFFF_FFFF};

    v = '{1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0};
    drive(v);
    #1;
    push("pre_reset_r0", 32'd0, 32'd0);
    pop_check();

    for (int i = 0; i < 13; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Read-during-write: the old value holds until the edge, and the new value is visible after it.
    @(negedge i_clk);
    v = '{1'b1, 1'b1, 5'd4, 32'd108, 5'd4, 5'd4, 32'd108, 32'd108};
    drive(v);
    #1;
    push("rdw_before", 32'd86, 32'd86);
    pop_check();
    push("rdw_after", v.e1, v.e2);
    @(posedge i_clk);
    #1;
    pop_check();

    // Reset priority: the write in the reset cycle is lost, and the next write lands.
    apply("rst_prio", '{1'b0, 1'b1, 5'd1, 32'd69, 5'd1, 5'd4, 32'd0, 32'd0});
    apply("post_rst", '{1'b1, 1'b1, 5'd1, 32'd69, 5'd1, 5'd4, 32'd69, 32'd0});
    apply("hold_r1", '{1'b1, 1'b0, 5'd1, 32'd5, 5'd1, 5'd1, 32'd69, 32'd69});

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_left: got %0d entries, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

General-purpose register file for the 32-bit MIPS single-cycle datapath: 32 registers of 32 bits, two combinational read ports (rs, rt operands), one synchronous write port (rd/rt destination). Sits between instruction decode and the ALU. The write-back mux drives the write port.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH = 32

Ports, in this positional order:
- i_clk  input  1  clock; all state changes on the rising edge
- i_rst_n  input  1  reset; synchronous and active-low
- rs1_reg  input  ADDR_WIDTH  read port 1 register index
- rs2_reg  input  ADDR_WIDTH  read port 2 register index
- rw_reg  input  ADDR_WIDTH  write register index
- reg_write  input  1  write enable, active-high
- wr_data  input  DATA_WIDTH  write data
- rs1_read  output  DATA_WIDTH  contents of register rs1_reg
- rs2_read  output  DATA_WIDTH  contents of register rs2_reg

## Operation
- Storage: array of 32 × DATA_WIDTH flip-flops, regs[0..31].
- Reset: a rising edge of i_clk with i_rst_n = 0 clears all 32 registers to 0. Reset has priority over any write in the same cycle.
- Write: a rising edge with i_rst_n = 1, reg_write = 1 and rw_reg ≠ 0 sets regs[rw_reg] to wr_data. All other registers hold their values.
- Register 0 is hardwired to zero, following the MIPS $zero convention. Writes to index 0 are silently discarded, and reads of index 0 always return 0.
- With reg_write = 0, no register changes, regardless of rw_reg and wr_data.
- Reads are purely combinational:
  - rs1_read = (rs1_reg == 0) ? 0 : regs[rs1_reg]
  - rs2_read = (rs2_reg == 0) ? 0 : regs[rs2_reg]
- Both read ports are independent and may address the same register simultaneously.
- No write-to-read bypass. A read of the register being written returns the old value until the clock edge, then the new value.
- No overflow or width conversion. wr_data is stored verbatim at full DATA_WIDTH.

## Timing
- Write latency: 1 cycle. Data is visible on the read ports immediately after the rising edge that captures it.
- Read latency: 0 cycles (combinational from rs*_reg and register state).
- Output reset value: after the first rising edge with i_rst_n = 0, both read ports output 0 for every address.
  - Before any reset edge, register contents are undefined except index 0, which reads 0.
- Reset mid-operation: asserting i_rst_n = 0 with reg_write = 1 clears all registers on that edge, and the write is lost. After i_rst_n returns to 1, the next edge with reg_write = 1 writes normally.
- Same-edge write and read of the same index: the read output changes only after the edge (old → new).
- X/undefined read addresses produce undefined outputs. There is no requirement beyond that.

## Structure
- Shared package `mips_pkg`: DATA_WIDTH = 32, ADDR_WIDTH = 5, NUM_REGS = 32, and the REG_ZERO = 5'd0 constant.
- Single flat module. No sub-module is needed: one always block for the synchronous reset/write, two continuous-assign read muxes.

## Test plan
- Reset: i_rst_n = 0 for 2 cycles, then release. Read rs1_reg = 5, rs2_reg = 31 -> both outputs 0.
- Basic write/read: write 68 to r1, then 48 to r2, one per cycle with reg_write = 1. Set rs1_reg = 1, rs2_reg = 2 -> rs1_read = 68, rs2_read = 48. Swap the indices -> outputs swap.
- $zero: write 43 to r0 with reg_write = 1. Read rs1_reg = 0 -> 0.
- Write disable: r3 = 73, then drive rw_reg = 3, wr_data = 88, reg_write = 0 for 3 edges -> r3 reads 73.
- Read-during-write: with r4 = 86, drive rw_reg = 4, wr_data = 108, reg_write = 1, rs1_reg = rs2_reg = 4.
  - Before the edge, both outputs read 86.
  - After the edge, both read 108.
- Reset priority: with r1 = 68, assert i_rst_n = 0 with rw_reg = 1, wr_data = 69, reg_write = 1 -> after the edge, r1 reads 0. Release reset and write 69 -> r1 reads 69 the next cycle.
